// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and defaults for the hazard detector slice
package game_pkg;

    typedef logic [9:0]  coord_t;
    typedef logic [11:0] wide_t;

    typedef enum logic [1:0] {
        HD_IDLE,
        HD_SCAN,
        HD_REPORT
    } hd_state_t;

    localparam int FINISH_X_DEFAULT     = 600;
    localparam int N_OBS_DEFAULT        = 4;
    localparam int GRACE_FRAMES_DEFAULT = 30;

    // Widened before subtracting so the distance never wraps.
    function automatic wide_t abs_diff(input wide_t a, input wide_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/hazard_detector_if.sv
// rtl/hazard_detector_if.sv - ball/obstacle inputs and hazard report outputs
interface hazard_detector_if
    import game_pkg::*;
#(
    parameter int N_OBS = N_OBS_DEFAULT
);

    logic                    frame_tick;
    logic                    enable;
    logic                    level_reset;
    coord_t                  ball_x;
    coord_t                  ball_y;
    coord_t                  ball_size;
    logic [N_OBS*10-1:0]     obs_x;
    logic [N_OBS*10-1:0]     obs_y;
    coord_t                  obs_size;
    logic [N_OBS-1:0]        obs_active;

    logic                    collision;
    logic                    finish_line_reached;
    logic [3:0]              hit_index;
    logic                    busy;
    logic                    overrun;
    logic [7:0]              hit_count;

    // Motion/level side drives the geometry and controls.
    modport master (
        output frame_tick, enable, level_reset,
        output ball_x, ball_y, ball_size,
        output obs_x, obs_y, obs_size, obs_active,
        input  collision, finish_line_reached, hit_index,
        input  busy, overrun, hit_count
    );

    modport slave (
        input  frame_tick, enable, level_reset,
        input  ball_x, ball_y, ball_size,
        input  obs_x, obs_y, obs_size, obs_active,
        output collision, finish_line_reached, hit_index,
        output busy, overrun, hit_count
    );

endinterface

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - combinational axis-aligned box overlap test on centres
module aabb_overlap
    import game_pkg::*;
(
    input  coord_t a_x,
    input  coord_t a_y,
    input  coord_t a_size,
    input  coord_t b_x,
    input  coord_t b_y,
    input  coord_t b_size,
    output logic   overlap
);

    wide_t dist_x;
    wide_t dist_y;
    wide_t reach;

    assign dist_x  = abs_diff(wide_t'(a_x), wide_t'(b_x));
    assign dist_y  = abs_diff(wide_t'(a_y), wide_t'(b_y));
    assign reach   = wide_t'(a_size) + wide_t'(b_size);
    assign overlap = (dist_x < reach) && (dist_y < reach);

endmodule

// File: rtl/hazard_detector.sv
// rtl/hazard_detector.sv - per-frame collision/finish detector with post-hit grace period
module hazard_detector
    import game_pkg::*;
#(
    parameter int N_OBS        = N_OBS_DEFAULT,
    parameter int FINISH_X     = FINISH_X_DEFAULT,
    parameter int GRACE_FRAMES = GRACE_FRAMES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    hazard_detector_if.slave hd
);

    localparam logic [3:0] LAST_IDX   = 4'(N_OBS - 1);
    localparam logic [7:0] GRACE_LOAD = 8'(GRACE_FRAMES);
    localparam wide_t      FINISH_W   = wide_t'(FINISH_X);

    hd_state_t  state_q, state_d;
    logic [3:0] idx_q, idx_d;
    coord_t     bx_q, bx_d;
    coord_t     by_q, by_d;
    coord_t     bs_q, bs_d;
    coord_t     os_q, os_d;
    logic       hit_flag_q, hit_flag_d;
    logic [3:0] hit_slot_q, hit_slot_d;
    logic       gate_q, gate_d;
    logic [7:0] grace_q, grace_d;
    logic       collision_q, collision_d;
    logic       finish_q, finish_d;
    logic [3:0] hit_index_q, hit_index_d;
    logic [7:0] hit_count_q, hit_count_d;
    logic       overrun_q, overrun_d;

    coord_t slot_x;
    coord_t slot_y;
    logic   slot_active;
    logic   slot_overlap;
    logic   slot_hit;
    logic   finish_hit;

    // Obstacle positions are sampled live, one slot per clock.
    assign slot_x      = coord_t'(hd.obs_x >> (32'(idx_q) * 10));
    assign slot_y      = coord_t'(hd.obs_y >> (32'(idx_q) * 10));
    assign slot_active = 1'(hd.obs_active >> idx_q);
    assign slot_hit    = slot_active && slot_overlap;
    assign finish_hit  = (wide_t'(bx_q) + wide_t'(bs_q)) >= FINISH_W;

    aabb_overlap u_aabb (
        .a_x    (bx_q),
        .a_y    (by_q),
        .a_size (bs_q),
        .b_x    (slot_x),
        .b_y    (slot_y),
        .b_size (os_q),
        .overlap(slot_overlap)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bx_d        = bx_q;
        by_d        = by_q;
        bs_d        = bs_q;
        os_d        = os_q;
        hit_flag_d  = hit_flag_q;
        hit_slot_d  = hit_slot_q;
        gate_d      = gate_q;
        grace_d     = grace_q;
        collision_d = 1'b0;
        finish_d    = 1'b0;
        hit_index_d = hit_index_q;
        hit_count_d = hit_count_q;
        overrun_d   = overrun_q;

        if (hd.frame_tick && (grace_q != 8'd0)) begin
            grace_d = grace_q - 8'd1;
        end

        case (state_q)
            HD_IDLE: begin
                if (hd.frame_tick && hd.enable) begin
                    state_d    = HD_SCAN;
                    idx_d      = 4'd0;
                    bx_d       = hd.ball_x;
                    by_d       = hd.ball_y;
                    bs_d       = hd.ball_size;
                    os_d       = hd.obs_size;
                    hit_flag_d = 1'b0;
                    // Immunity is judged by the grace count when the frame starts.
                    gate_d     = (grace_q == 8'd0);
                end
            end
            HD_SCAN: begin
                if (hd.frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (slot_hit && !hit_flag_q) begin
                    hit_flag_d = 1'b1;
                    hit_slot_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = HD_REPORT;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            HD_REPORT: begin
                if (hd.frame_tick) begin
                    overrun_d = 1'b1;
                end
                state_d = HD_IDLE;
                if (hd.enable && gate_q) begin
                    if (hit_flag_q) begin
                        collision_d = 1'b1;
                        grace_d     = GRACE_LOAD;
                        hit_index_d = hit_slot_q;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_d = hit_count_q + 8'd1;
                        end
                    end else if (finish_hit) begin
                        finish_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = HD_IDLE;
            end
        endcase

        // Level restart abandons the frame outright and overrides any tick.
        if (hd.level_reset) begin
            state_d     = HD_IDLE;
            collision_d = 1'b0;
            finish_d    = 1'b0;
            grace_d     = GRACE_LOAD;
            hit_index_d = hit_index_q;
            hit_count_d = hit_count_q;
            overrun_d   = overrun_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HD_IDLE;
            idx_q       <= 4'd0;
            bx_q        <= '0;
            by_q        <= '0;
            bs_q        <= '0;
            os_q        <= '0;
            hit_flag_q  <= 1'b0;
            hit_slot_q  <= 4'd0;
            gate_q      <= 1'b0;
            grace_q     <= 8'd0;
            collision_q <= 1'b0;
            finish_q    <= 1'b0;
            hit_index_q <= 4'd0;
            hit_count_q <= 8'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            bs_q        <= bs_d;
            os_q        <= os_d;
            hit_flag_q  <= hit_flag_d;
            hit_slot_q  <= hit_slot_d;
            gate_q      <= gate_d;
            grace_q     <= grace_d;
            collision_q <= collision_d;
            finish_q    <= finish_d;
            hit_index_q <= hit_index_d;
            hit_count_q <= hit_count_d;
            overrun_q   <= overrun_d;
        end
    end

    assign hd.collision           = collision_q;
    assign hd.finish_line_reached = finish_q;
    assign hd.hit_index           = hit_index_q;
    assign hd.busy                = (state_q != HD_IDLE);
    assign hd.overrun             = overrun_q;
    assign hd.hit_count           = hit_count_q;

endmodule

// File: tb/tb_hazard_detector.sv
// tb/tb_hazard_detector.sv - randomized self-checking bench for hazard_detector
module tb_hazard_detector;
    import game_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_detector_if #(.N_OBS(N)) ifa ();
    hazard_detector_if #(.N_OBS(N)) ifb ();

    hazard_detector #(.N_OBS(N), .FINISH_X(600), .GRACE_FRAMES(30)) dut (
        .clk(clk), .reset(reset), .hd(ifa)
    );
    hazard_detector #(.N_OBS(N), .FINISH_X(600), .GRACE_FRAMES(0)) dut_g0 (
        .clk(clk), .reset(reset), .hd(ifb)
    );

    assign ifb.frame_tick  = ifa.frame_tick;
    assign ifb.enable      = ifa.enable;
    assign ifb.level_reset = ifa.level_reset;
    assign ifb.ball_x      = ifa.ball_x;
    assign ifb.ball_y      = ifa.ball_y;
    assign ifb.ball_size   = ifa.ball_size;
    assign ifb.obs_x       = ifa.obs_x;
    assign ifb.obs_y       = ifa.obs_y;
    assign ifb.obs_size    = ifa.obs_size;
    assign ifb.obs_active  = ifa.obs_active;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: 0 = grace 30, 1 = grace 0
    int grace_m [2];
    int cnt_m   [2];
    int idx_m   [2];
    int ovr_m   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int grace_of(input int k);
        return (k == 0) ? 30 : 0;
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit slot_overlaps(input int i);
        int ox, oy, reach;
        ox    = int'(ifa.obs_x[i*10 +: 10]);
        oy    = int'(ifa.obs_y[i*10 +: 10]);
        reach = int'(ifa.ball_size) + int'(ifa.obs_size);
        return ifa.obs_active[i] &&
               (absi(int'(ifa.ball_x) - ox) < reach) &&
               (absi(int'(ifa.ball_y) - oy) < reach);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            grace_m[k] = 0; cnt_m[k] = 0; idx_m[k] = 0; ovr_m[k] = 0;
        end
    endtask

    task automatic model_tick(input int k);
        if (grace_m[k] > 0) grace_m[k]--;
    endtask

    task automatic set_ball(input int x, input int y, input int s, input int os);
        ifa.ball_x = 10'(x); ifa.ball_y = 10'(y); ifa.ball_size = 10'(s); ifa.obs_size = 10'(os);
    endtask

    task automatic set_slot(input int i, input int x, input int y, input bit a);
        ifa.obs_x[i*10 +: 10] = 10'(x);
        ifa.obs_y[i*10 +: 10] = 10'(y);
        ifa.obs_active[i]     = a;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_coll_a"}, ifa.collision, 0);
        check({tag, "_fin_a"},  ifa.finish_line_reached, 0);
        check({tag, "_coll_b"}, ifb.collision, 0);
        check({tag, "_fin_b"},  ifb.finish_line_reached, 0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_idx_a"}, ifa.hit_index, idx_m[0]);
        check({tag, "_cnt_a"}, ifa.hit_count, cnt_m[0]);
        check({tag, "_ovr_a"}, ifa.overrun, ovr_m[0]);
        check({tag, "_idx_b"}, ifb.hit_index, idx_m[1]);
        check({tag, "_cnt_b"}, ifb.hit_count, cnt_m[1]);
        check({tag, "_ovr_b"}, ifb.overrun, ovr_m[1]);
    endtask

    // One frame: tick, optional second tick while busy, optional enable drop mid-scan.
    task automatic run_frame(input string tag, input bit extra_tick, input bit drop_en);
        bit hit, fin, en0, gate;
        int low;
        bit exp_c [2];
        bit exp_f [2];
        hit = 0; low = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (slot_overlaps(i)) begin hit = 1; low = i; end
        end
        fin = (int'(ifa.ball_x) + int'(ifa.ball_size)) >= 600;
        en0 = ifa.enable;
        for (int k = 0; k < 2; k++) begin
            gate = (grace_m[k] == 0);
            model_tick(k);
            if (extra_tick) begin
                model_tick(k);
                if (en0) ovr_m[k] = 1;
            end
            exp_c[k] = 0; exp_f[k] = 0;
            if (en0 && !drop_en && gate) begin
                if (hit) begin
                    exp_c[k]   = 1;
                    grace_m[k] = grace_of(k);
                    idx_m[k]   = low;
                    if (cnt_m[k] < 255) cnt_m[k]++;
                end else if (fin) begin
                    exp_f[k] = 1;
                end
            end
        end

        @(posedge clk); #1 ifa.frame_tick = 1'b1;
        @(posedge clk); #1 ifa.frame_tick = 1'b0;
        check({tag, "_busy_a"}, ifa.busy, en0);
        check({tag, "_busy_b"}, ifb.busy, en0);
        if (extra_tick) ifa.frame_tick = 1'b1;
        @(posedge clk); #1 ifa.frame_tick = 1'b0;
        if (drop_en) ifa.enable = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_quiet({tag, "_early"});
        @(posedge clk); #1;
        check({tag, "_coll_a"}, ifa.collision, exp_c[0]);
        check({tag, "_fin_a"},  ifa.finish_line_reached, exp_f[0]);
        check({tag, "_coll_b"}, ifb.collision, exp_c[1]);
        check({tag, "_fin_b"},  ifb.finish_line_reached, exp_f[1]);
        check_state(tag);
        @(posedge clk); #1;
        check_quiet({tag, "_late"});
        check({tag, "_idle_a"}, ifa.busy, 0);
        check({tag, "_idle_b"}, ifb.busy, 0);
        ifa.enable = en0;
    endtask

    task automatic idle_frames(input int n);
        ifa.enable = 1'b0;
        for (int i = 0; i < n; i++) run_frame("idle", 0, 0);
        ifa.enable = 1'b1;
    endtask

    task automatic abort_frame();
        for (int k = 0; k < 2; k++) begin
            model_tick(k);
            grace_m[k] = grace_of(k);
        end
        @(posedge clk); #1 ifa.frame_tick = 1'b1;
        @(posedge clk); #1 ifa.frame_tick = 1'b0;
        @(posedge clk); #1 ifa.level_reset = 1'b1;
        @(posedge clk); #1 ifa.level_reset = 1'b0;
        check("abort_busy_a", ifa.busy, 0);
        check("abort_busy_b", ifb.busy, 0);
        repeat (6) begin
            @(posedge clk); #1;
            check_quiet("abort");
        end
        check_state("abort");
    endtask

    initial begin
        int bx, by;
        ifa.frame_tick = 0; ifa.enable = 1; ifa.level_reset = 0;
        ifa.obs_x = '0; ifa.obs_y = '0; ifa.obs_active = '0;
        set_ball(0, 0, 0, 0);
        model_reset();
        #1 reset = 1'b1;
        #1;
        check_quiet("rst");
        check("rst_busy", ifa.busy, 0);
        check_state("rst");
        #10 reset = 1'b0;

        // Basic hit, then grace window of 30 frames
        set_ball(100, 100, 8, 8);
        set_slot(0, 110, 100, 1);
        run_frame("t1", 0, 0);
        check("t1_index", ifa.hit_index, 0);
        check("t1_count", ifa.hit_count, 1);
        for (int i = 0; i < 30; i++) run_frame("t2_grace", 0, 0);
        check("t2_count_before", ifa.hit_count, 1);
        run_frame("t2_again", 0, 0);
        check("t2_count", ifa.hit_count, 2);
        idle_frames(30);

        // Finish line, then collision wins on the same frame
        ifa.obs_active = '0;
        set_ball(595, 240, 8, 8);
        run_frame("t3_finish", 0, 0);
        set_slot(2, 600, 240, 1);
        run_frame("t3_coll", 0, 0);
        check("t3_index", ifa.hit_index, 2);
        idle_frames(30);

        // Near the origin: distance must not wrap
        ifa.obs_active = '0;
        set_ball(5, 5, 8, 4);
        set_slot(0, 2, 2, 1);
        run_frame("t4_near", 0, 0);
        idle_frames(30);
        set_slot(0, 40, 5, 1);
        run_frame("t4_far", 0, 0);

        // Aborted frame, its grace window, overrun and enable drop
        set_slot(0, 2, 2, 1);
        abort_frame();
        for (int i = 0; i < 31; i++) run_frame("t5_after", 0, 0);
        run_frame("t5_overrun", 1, 0);
        check("t5_overrun", ifa.overrun, 1);
        run_frame("t5_dropen", 0, 1);

        // Randomized frames
        for (int n = 0; n < 150; n++) begin
            bx = $urandom_range(0, 620);
            by = $urandom_range(0, 479);
            set_ball(bx, by, $urandom_range(0, 20), $urandom_range(0, 20));
            for (int i = 0; i < N; i++) begin
                set_slot(i, bx + $urandom_range(0, 80) - 40 < 0 ? 0 : bx + $urandom_range(0, 80) - 40,
                         by + $urandom_range(0, 80) - 40 < 0 ? 0 : by + $urandom_range(0, 80) - 40,
                         $urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 29) == 0) begin
                abort_frame();
            end else begin
                ifa.enable = ($urandom_range(0, 9) != 0);
                run_frame("rnd", ifa.enable && ($urandom_range(0, 19) == 0),
                          ifa.enable && ($urandom_range(0, 19) == 0));
            end
            ifa.enable = 1'b1;
        end

        // Saturation on the zero-grace instance
        ifa.obs_active = '0;
        set_ball(300, 300, 10, 10);
        set_slot(1, 305, 295, 1);
        for (int i = 0; i < 300; i++) run_frame("t6_sat", 0, 0);
        check("t6_sat_b", ifb.hit_count, 255);

        // Asynchronous reset in the middle of a scan
        @(posedge clk); #1 ifa.frame_tick = 1'b1;
        @(posedge clk); #1 ifa.frame_tick = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        #1;
        model_reset();
        check("rstmid_busy_a", ifa.busy, 0);
        check("rstmid_busy_b", ifb.busy, 0);
        check_quiet("rstmid");
        check_state("rstmid");
        @(posedge clk); #1 reset = 1'b0;
        run_frame("post_rst", 0, 0);
        check("post_rst_cnt", ifa.hit_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
